// File: rtl/dmx_frame_decoder_if.sv
// Bus between the DMX byte receiver / fixture logic and the frame decoder.
// The master drives the line, byte stream and start address; the slave publishes the captured channels.
interface dmx_frame_decoder_if #(
    parameter int NUM_CH = 4
);
    logic                  dmx_in;
    logic                  byte_ready;
    logic [7:0]            received_byte;
    logic [8:0]            start_addr;
    logic [8*NUM_CH-1:0]   ch_data;
    logic                  ch_valid;
    logic                  frame_done;
    logic [9:0]            slot_count;
    logic                  signal_ok;

    modport master (
        output dmx_in, byte_ready, received_byte, start_addr,
        input  ch_data, ch_valid, frame_done, slot_count, signal_ok
    );

    modport slave (
        input  dmx_in, byte_ready, received_byte, start_addr,
        output ch_data, ch_valid, frame_done, slot_count, signal_ok
    );
endinterface

// File: rtl/dmx_frame_decoder.sv
// DMX512 frame decoder: break detection, start-code filtering, slot numbering and
// capture of NUM_CH consecutive slots from a runtime start address.
module dmx_frame_decoder #(
    parameter int CLK_FREQ     = 20_000_000,
    parameter int BREAK_MIN_US = 88,
    parameter int NUM_CH       = 4,
    parameter int LOSS_CYCLES  = 20_000_000
) (
    input  logic               clk,
    input  logic               rst,
    dmx_frame_decoder_if.slave bus_io
);
    localparam int BREAK_CYCLES = CLK_FREQ / 1_000_000 * BREAK_MIN_US;
    localparam int BW           = $clog2(BREAK_CYCLES + 1);
    localparam int LW           = $clog2(LOSS_CYCLES + 1);
    localparam logic [BW-1:0] BREAK_MAX = BW'(BREAK_CYCLES);
    localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_START, DATA, IGNORE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic [BW-1:0]       low_q, low_d;
    logic                line_s, break_end_s;
    logic [9:0]          slot_q, slot_d, n_s, last_s;
    logic [8:0]          addr_q, addr_d;
    logic                win_ok_s;
    logic [8*NUM_CH-1:0] shadow_q, shadow_d, ch_data_q, ch_data_d;
    logic                ch_valid_q, ch_valid_d, frame_done_q, frame_done_d;
    logic [9:0]          slot_count_q, slot_count_d;
    logic [LW-1:0]       loss_q, loss_d;
    logic                ok_q, ok_d;

    assign line_s      = sync_q[1];
    assign break_end_s = line_s && (low_q == BREAK_MAX);
    assign n_s         = slot_q + 10'd1;
    assign last_s      = {1'b0, addr_q} + 10'(NUM_CH - 1);
    assign win_ok_s    = (addr_q != 9'd0) && (last_s <= 10'd512);

    // Saturating low-time counter on the synchronized line.
    always_comb begin
        low_d = low_q;
        if (!line_s) begin
            low_d = (low_q == BREAK_MAX) ? low_q : low_q + BW'(1);
        end else begin
            low_d = '0;
        end
    end

    // Next-state, slot capture, frame statistics and loss timer.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        addr_d       = addr_q;
        shadow_d     = shadow_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        slot_count_d = slot_count_q;
        loss_d       = (loss_q == '0) ? loss_q : loss_q - LW'(1);

        if (break_end_s) begin
            // A break always wins over a coincident byte strobe.
            state_d = WAIT_START;
            slot_d  = 10'd0;
            addr_d  = bus_io.start_addr;
            if (state_q == DATA) begin
                frame_done_d = 1'b1;
                slot_count_d = slot_q;
            end else begin
                frame_done_d = 1'b0;
            end
        end else if (bus_io.byte_ready) begin
            case (state_q)
                WAIT_START: begin
                    if (bus_io.received_byte == 8'h00) begin
                        state_d = DATA;
                        loss_d  = LOSS_MAX;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                DATA: begin
                    if (slot_q != 10'd512) begin
                        slot_d = n_s;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (win_ok_s && (n_s == {1'b0, addr_q} + 10'(i))) begin
                                shadow_d[8*i +: 8] = bus_io.received_byte;
                            end else begin
                                shadow_d[8*i +: 8] = shadow_d[8*i +: 8];
                            end
                        end
                        if (win_ok_s && (n_s == last_s)) begin
                            ch_data_d  = shadow_d;
                            ch_valid_d = 1'b1;
                        end else begin
                            ch_valid_d = 1'b0;
                        end
                    end else begin
                        slot_d = slot_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        ok_d = (loss_d != '0);
    end

    // State, synchronizer and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            low_q        <= '0;
            slot_q       <= 10'd0;
            addr_q       <= 9'd0;
            shadow_q     <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            slot_count_q <= 10'd0;
            loss_q       <= '0;
            ok_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], bus_io.dmx_in};
            low_q        <= low_d;
            slot_q       <= slot_d;
            addr_q       <= addr_d;
            shadow_q     <= shadow_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            slot_count_q <= slot_count_d;
            loss_q       <= loss_d;
            ok_q         <= ok_d;
        end
    end

    assign bus_io.ch_data    = ch_data_q;
    assign bus_io.ch_valid   = ch_valid_q;
    assign bus_io.frame_done = frame_done_q;
    assign bus_io.slot_count = slot_count_q;
    assign bus_io.signal_ok  = ok_q;
endmodule

// File: tb/tb_dmx_frame_decoder.sv
// Directed bench for dmx_frame_decoder: frame scenarios from a vector table plus
// hand-written sequences for output latency, signal loss and mid-frame reset.
module tb_dmx_frame_decoder;
    localparam int NUM_CH = 4;
    localparam int LOSS   = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   vcnt  = 0;
    int   dcnt  = 0;

    dmx_frame_decoder_if #(.NUM_CH(NUM_CH)) bus ();

    dmx_frame_decoder #(
        .CLK_FREQ    (20_000_000),
        .BREAK_MIN_US(88),
        .NUM_CH      (NUM_CH),
        .LOSS_CYCLES (LOSS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ch_valid)   vcnt <= vcnt + 1;
        if (bus.frame_done) dcnt <= dcnt + 1;
    end

    typedef struct {
        int          lead;
        logic [7:0]  sc;
        int          nsl;
        logic [8:0]  addr;
        bit          tail;
        int          ev;
        int          ed;
        logic [9:0]  esc;
        logic [31:0] ech;
        logic        eok;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic low_pulse(input int len);
        bus.dmx_in = 1'b0;
        repeat (len) tick();
        bus.dmx_in = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_ready    = 1'b1;
        bus.received_byte = b;
        tick();
        bus.byte_ready    = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] slot_byte(input int k);
        logic [31:0] p;
        p = k * 17;
        return p[7:0];
    endfunction

    initial begin
        int acc_cyc, v0, d0;
        bus.dmx_in        = 1'b1;
        bus.byte_ready    = 1'b0;
        bus.received_byte = 8'h00;
        bus.start_addr    = 9'd2;

        vt[0] = '{1700, 8'h00,   5, 9'd2,   1'b0, 0, 0, 10'd0,   32'h00000000, 1'b0};
        vt[1] = '{1800, 8'h00,   5, 9'd2,   1'b1, 1, 1, 10'd5,   32'h55443322, 1'b1};
        vt[2] = '{1800, 8'hCC,  10, 9'd2,   1'b1, 0, 0, 10'd5,   32'h55443322, 1'b1};
        vt[3] = '{1800, 8'h00, 300, 9'd7,   1'b1, 1, 1, 10'd300, 32'hAA998877, 1'b1};
        vt[4] = '{1800, 8'h00, 520, 9'd2,   1'b1, 1, 1, 10'd512, 32'h55443322, 1'b1};
        vt[5] = '{1800, 8'h00, 512, 9'd510, 1'b1, 0, 1, 10'd512, 32'h55443322, 1'b1};
        vt[6] = '{1800, 8'h00,   3, 9'd2,   1'b1, 0, 1, 10'd3,   32'h55443322, 1'b1};
        vt[7] = '{1800, 8'h00, 512, 9'd509, 1'b1, 1, 1, 10'd512, 32'h00EFDECD, 1'b1};
        vt[8] = '{1800, 8'h00,  10, 9'd0,   1'b1, 0, 1, 10'd10,  32'h00EFDECD, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_ch_data", 64'(bus.ch_data), 64'h0);
        chk("rst_ch_valid", 64'(bus.ch_valid), 64'h0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'h0);
        chk("rst_slot_count", 64'(bus.slot_count), 64'h0);
        chk("rst_signal_ok", 64'(bus.signal_ok), 64'h0);
        rst = 1'b0;
        repeat (3) tick();

        // Output latency: ch_valid and ch_data on the edge that samples the 5th strobe
        low_pulse(1800);
        bus.byte_ready = 1'b1;
        bus.received_byte = 8'h00;
        tick();
        acc_cyc = cyc;
        bus.byte_ready = 1'b0;
        chk("ok_on_accept", 64'(bus.signal_ok), 64'h1);
        tick();
        for (int k = 1; k <= 4; k++) send_byte(slot_byte(k));
        chk("valid_before_last", 64'(bus.ch_valid), 64'h0);
        bus.byte_ready = 1'b1;
        bus.received_byte = slot_byte(5);
        tick();
        bus.byte_ready = 1'b0;
        chk("latency_valid", 64'(bus.ch_valid), 64'h1);
        chk("latency_data", 64'(bus.ch_data), 64'h55443322);
        tick();
        chk("valid_one_clock", 64'(bus.ch_valid), 64'h0);

        // Signal loss: ok falls exactly LOSS clocks after acceptance
        while (bus.signal_ok && (cyc - acc_cyc) <= LOSS + 10) tick();
        chk("loss_timing", 64'(cyc - acc_cyc), 64'(LOSS));
        chk("loss_ok_low", 64'(bus.signal_ok), 64'h0);

        // Reset asserted mid-DATA clears outputs immediately
        low_pulse(1800);
        send_byte(8'h00);
        send_byte(slot_byte(1));
        send_byte(slot_byte(2));
        rst = 1'b1;
        #1;
        chk("midrst_ch_data", 64'(bus.ch_data), 64'h0);
        chk("midrst_signal_ok", 64'(bus.signal_ok), 64'h0);
        chk("midrst_slot_count", 64'(bus.slot_count), 64'h0);
        chk("midrst_valid_done", 64'({bus.ch_valid, bus.frame_done}), 64'h0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Table of frame scenarios
        for (int i = 0; i < 9; i++) begin
            v0 = vcnt;
            d0 = dcnt;
            bus.start_addr = vt[i].addr;
            low_pulse(vt[i].lead);
            send_byte(vt[i].sc);
            for (int k = 1; k <= vt[i].nsl; k++) send_byte(slot_byte(k));
            if (vt[i].tail) low_pulse(1800);
            tick();
            chk($sformatf("v%0d_valid_cnt", i), 64'(vcnt - v0), 64'(vt[i].ev));
            chk($sformatf("v%0d_done_cnt", i), 64'(dcnt - d0), 64'(vt[i].ed));
            chk($sformatf("v%0d_slot_count", i), 64'(bus.slot_count), 64'(vt[i].esc));
            chk($sformatf("v%0d_ch_data", i), 64'(bus.ch_data), 64'(vt[i].ech));
            chk($sformatf("v%0d_signal_ok", i), 64'(bus.signal_ok), 64'(vt[i].eok));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmx_frame_decoder.md
Name: dmx_frame_decoder

Overview:
- Sits directly downstream of the DMX byte receiver. Consumes its one-clock byte strobes plus the raw DMX line, and recovers DMX512 frame structure: break, start code and slot numbering.
- Captures a window of NUM_CH consecutive slots beginning at a runtime start address. Publishes them as a parallel channel bus with a one-clock update strobe, for the fixture/PWM logic downstream.
- Also reports per-frame slot count and a signal-present status.

Parameters:
- CLK_FREQ, 20_000_000, system clock frequency in Hz.
- BREAK_MIN_US, 88, minimum low time in µs that qualifies as a break.
- NUM_CH, 4, number of consecutive slots captured (1..16).
- LOSS_CYCLES, 20_000_000, clocks without a valid frame start before signal_ok drops (1 s at default clock).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- dmx_in  input  1  raw asynchronous DMX line (same net that feeds the byte receiver).
- byte_ready  input  1  one-clock strobe from the byte receiver; received_byte is valid in that cycle.
- received_byte  input  8  byte from the byte receiver.
- start_addr  input  9  first slot to capture, 1..511 (9-bit range); 0 disables capture.
- ch_data  output  8*NUM_CH  captured slots; slot start_addr is in bits [7:0], ascending.
- ch_valid  output  1  one-clock strobe when ch_data has been updated.
- frame_done  output  1  one-clock strobe when a data frame ends.
- slot_count  output  10  number of data slots (0..512) in the last completed frame.
- signal_ok  output  1  high while valid frames keep arriving.

Behaviour:
- Reset values: ch_data=0, ch_valid=0, frame_done=0, slot_count=0, signal_ok=0, state=IDLE, all counters 0.
- dmx_in passes through a 2-FF synchronizer (reset to 1) before use.

Break detection:
- BREAK_CYCLES = CLK_FREQ/1_000_000*BREAK_MIN_US (1760 at defaults).
- A low-time counter increments while the synchronized line is 0, saturates at BREAK_CYCLES, and clears when the line is 1.
- break_end is an internal one-clock event: the line rises while the counter equals BREAK_CYCLES.
- Low periods shorter than BREAK_CYCLES are ignored; they are normal data bits.

FSM states: IDLE, WAIT_START, DATA, IGNORE.
- IDLE: byte_ready is ignored. break_end goes to WAIT_START.
- WAIT_START: entry clears the slot counter and latches start_addr into an internal register. Mid-frame start_addr changes therefore take effect next frame.
  - byte_ready with byte 0x00 goes to DATA, and reloads the loss timer.
  - byte_ready with any other byte goes to IGNORE (non-dimmer start code).
- DATA: each byte_ready increments the slot counter; the first data byte is slot 1.
  - Slots beyond 512 are dropped, and the counter saturates at 512.
  - A slot n in [addr_l, addr_l+NUM_CH-1] is written into the shadow buffer at index n-addr_l.
  - When n == addr_l+NUM_CH-1, the buffer is written to ch_data with that byte included. ch_data and ch_valid=1 both appear on the clock edge after the byte_ready cycle (latency 1).
- IGNORE: byte_ready is ignored until break_end.

Break from any state:
- break_end in any state goes to WAIT_START.
- If the state was DATA, frame_done pulses one clock and slot_count takes the slot counter value on the same edge.
- A frame cut short before its last captured slot leaves ch_data unchanged and produces no ch_valid.

Edge cases:
- Window beyond slot 512, or addr_l=0: no capture and no ch_valid, ever.
- Simultaneous break_end and byte_ready: break_end wins and the byte is dropped.
- Loss timer: counts down each clock and reloads to LOSS_CYCLES on an accepted 0x00 start code.
  - signal_ok=1 on reload.
  - signal_ok=0 when the timer reaches 0; the FSM state is unaffected.
- Reset asserted mid-frame returns everything to reset values immediately; capture resumes only after a full break.

Test Plan:
- Break of 1800 clocks low, start 0x00, slots 0x11,0x22,0x33,0x44,0x55; start_addr=2, NUM_CH=4 -> ch_data=0x55443322, a single ch_valid pulse one clock after the 5th byte_ready, signal_ok=1.
- Same frame preceded by only a 1700-clock low (below 1760) -> no state change, no ch_valid, signal_ok stays 0.
- Break, start 0xCC, 10 bytes -> no ch_valid, no frame_done at the next break, ch_data unchanged.
- Break, 0x00, 300 slots, break -> frame_done pulse, slot_count=300. A second frame of 520 slots -> slot_count=512.
- start_addr=510, NUM_CH=4, full 512-slot frame -> no ch_valid. Frame cut by a break after slot 3 with start_addr=2 -> ch_data retains its previous value.
- Valid frame, then the line idles high for LOSS_CYCLES+10 clocks -> signal_ok falls exactly LOSS_CYCLES clocks after the start-code acceptance. rst pulse mid-DATA -> all outputs 0 the same cycle.
